// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller state enum, forward-select encoding and the
// forwarding priority helper used for both execute operands.
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } hz_state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF = 2'b00;
    localparam fwd_sel_t FWD_W  = 2'b01;
    localparam fwd_sel_t FWD_M  = 2'b10;

    // Memory stage wins over writeback; x0 is hardwired zero and never forwarded.
    function automatic fwd_sel_t fwd_select(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous active-low clear.
// Ports: clk, reset (sync, active-low), inc (count enable), cnt (current value).
// Holds at all-ones once reached; never wraps.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 core: stalls, flushes, execute
// forwarding selects and the start/done handshake with the iterative mul/div.
// Ports: decode/execute/memory/writeback register ids and enables in; stall,
// flush, forward-select, mc_start, sticky mc_timeout and event counters out.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int MC_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             LoadE,
    input  logic             MulDivE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             mc_done,
    output logic             mc_start,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mc_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MC_TIMEOUT - 1);

    hz_state_t         state_q, state_d, cur_state;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic              load_use;
    logic              branch_flush;

    assign ForwardAE = fwd_select(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    assign ForwardBE = fwd_select(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

    assign load_use = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // While reset is held the outputs behave as in RUN, so a pending MC_WAIT
    // is dropped without ever re-entering the wait handshake.
    assign cur_state = reset ? state_q : RUN;

    always_comb begin
        mc_start     = 1'b0;
        StallF       = 1'b0;
        StallD       = 1'b0;
        StallE       = 1'b0;
        FlushD       = 1'b0;
        FlushE       = 1'b0;
        FlushM       = 1'b0;
        branch_flush = 1'b0;
        state_d      = state_q;
        wait_d       = wait_q;
        timeout_d    = timeout_q;
        case (cur_state)
            RUN: begin
                if (PCSrcE) begin
                    // Decode holds a wrong-path instruction, so any load-use
                    // hazard against it is irrelevant.
                    FlushD       = 1'b1;
                    FlushE       = 1'b1;
                    branch_flush = 1'b1;
                end else if (load_use) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end else if (MulDivE) begin
                    mc_start = 1'b1;
                    StallF   = 1'b1;
                    StallD   = 1'b1;
                    StallE   = 1'b1;
                    FlushM   = 1'b1;
                    state_d  = MC_WAIT;
                    wait_d   = '0;
                end
            end
            MC_WAIT: begin
                if (mc_done) begin
                    // Stalls drop in this cycle so the result moves into E/M.
                    state_d = RUN;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = RUN;
                end else begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    FlushM = 1'b1;
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign mc_timeout = timeout_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (StallD),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (branch_flush),
        .cnt   (flush_cnt)
    );

    illegal_branch_muldiv: assert property (@(posedge clk) disable iff (!reset)
        !(PCSrcE && MulDivE));

endmodule
